// File: rtl/counter_seq_ctrl.sv
// Request-driven controller for a 4-bit up/down/load counter: takes a target over valid/ready,
// steps or loads the counter until it matches, then pulses done or err.
module counter_seq_ctrl #(
  parameter int MAX_VAL  = 12,
  parameter int LOCK_VAL = 15,
  parameter int TIMEOUT  = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_mode,
  input  logic [5:0] req_target,
  input  logic [3:0] cnt_out,
  output logic       cnt_en,
  output logic       cnt_dir,
  output logic       cnt_load,
  output logic [5:0] cnt_data,
  output logic       done,
  output logic       err,
  output logic [4:0] steps
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STEP   = 2'd2,
    REPORT = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] target_q, target_d;
  logic       cnt_en_q, cnt_en_d;
  logic       cnt_dir_q, cnt_dir_d;
  logic       cnt_load_q, cnt_load_d;
  logic [5:0] cnt_data_q, cnt_data_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [4:0] steps_q, steps_d;
  logic       req_ready_q, req_ready_d;

  logic [5:0] cnt_ext;
  logic       accept;
  logic       reject;
  logic       req_at_target;
  logic       at_target;
  logic       timed_out;

  assign cnt_ext       = {2'b00, cnt_out};
  assign accept        = req_valid & req_ready_q;
  // A locked or out-of-range counter cannot be steered, so refuse before driving it.
  assign reject        = (req_target > 6'(MAX_VAL)) || (cnt_out == 4'(LOCK_VAL)) ||
                         (cnt_out > 4'(MAX_VAL));
  assign req_at_target = (cnt_ext == req_target);
  assign at_target     = (cnt_ext == target_q);
  assign timed_out     = (steps_q == 5'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      target_q    <= '0;
      cnt_en_q    <= 1'b0;
      cnt_dir_q   <= 1'b0;
      cnt_load_q  <= 1'b0;
      cnt_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      steps_q     <= '0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      cnt_en_q    <= cnt_en_d;
      cnt_dir_q   <= cnt_dir_d;
      cnt_load_q  <= cnt_load_d;
      cnt_data_q  <= cnt_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      steps_q     <= steps_d;
      req_ready_q <= req_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (reject)              state_d = REPORT;
          else if (req_mode)       state_d = LOAD;
          else if (req_at_target)  state_d = REPORT;
          else                     state_d = STEP;
        end
      end
      LOAD:   state_d = REPORT;
      STEP:   if (at_target || timed_out) state_d = REPORT;
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done/err are raised on entry to REPORT, so each lasts exactly one cycle.
  always_comb begin
    target_d    = target_q;
    cnt_en_d    = 1'b0;
    cnt_dir_d   = cnt_dir_q;
    cnt_load_d  = 1'b0;
    cnt_data_d  = cnt_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    steps_d     = steps_q;
    req_ready_d = (state_d == IDLE);
    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = req_target;
          steps_d  = '0;
          if (reject) begin
            err_d = 1'b1;
          end else if (req_mode) begin
            cnt_en_d   = 1'b1;
            cnt_load_d = 1'b1;
            cnt_data_d = req_target;
          end else if (req_at_target) begin
            done_d = 1'b1;
          end else begin
            cnt_en_d  = 1'b1;
            cnt_dir_d = (req_target > cnt_ext);
            steps_d   = 5'd1;
          end
        end
      end
      LOAD: begin
        if (at_target) done_d = 1'b1;
        else           err_d  = 1'b1;
      end
      STEP: begin
        if (at_target) begin
          done_d = 1'b1;
        end else if (timed_out) begin
          err_d = 1'b1;
        end else begin
          cnt_en_d  = 1'b1;
          cnt_dir_d = (target_q > cnt_ext);
          steps_d   = steps_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

  assign req_ready = req_ready_q;
  assign cnt_en    = cnt_en_q;
  assign cnt_dir   = cnt_dir_q;
  assign cnt_load  = cnt_load_q;
  assign cnt_data  = cnt_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign steps     = steps_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a negedge counter model driven by the cnt_* outputs.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_mode = 1'b0;
  logic [5:0] req_target = '0;
  logic [3:0] cnt_out;
  logic       cnt_en;
  logic       cnt_dir;
  logic       cnt_load;
  logic [5:0] cnt_data;
  logic       done;
  logic       err;
  logic [4:0] steps;

  logic [3:0] cnt_q = 4'd0;
  logic       freeze = 1'b0;
  logic       set_req = 1'b0;
  logic [3:0] set_val = 4'd0;

  int errors = 0;
  int checks = 0;

  counter_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_target (req_target),
    .cnt_out    (cnt_out),
    .cnt_en     (cnt_en),
    .cnt_dir    (cnt_dir),
    .cnt_load   (cnt_load),
    .cnt_data   (cnt_data),
    .done       (done),
    .err        (err),
    .steps      (steps)
  );

  always #5 clk = ~clk;

  assign cnt_out = cnt_q;

  // Counter model: updates on negedge, value 15 is sticky.
  always @(negedge clk) begin
    if (set_req) cnt_q <= set_val;
    else if (!freeze && cnt_en) begin
      if (cnt_load)          cnt_q <= cnt_data[3:0];
      else if (cnt_q != 4'd15) cnt_q <= cnt_dir ? cnt_q + 4'd1 : cnt_q - 4'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cnt(input logic [3:0] v);
    set_req = 1'b1;
    set_val = v;
    @(negedge clk);
    #1;
    set_req = 1'b0;
  endtask

  // Returns in cycle 1 of the request.
  task automatic send(input logic mode, input logic [5:0] target);
    req_valid  = 1'b1;
    req_mode   = mode;
    req_target = target;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready, cnt_en, cnt_dir, cnt_load, done, err} !== 6'b100000 || cnt_data !== 6'd0 || steps !== 5'd0) begin
      errors++;
      $display("FAIL reset_init: got rdy/en/dir/ld/done/err=%b data=%0d steps=%0d want 100000 0 0",
               {req_ready, cnt_en, cnt_dir, cnt_load, done, err}, cnt_data, steps);
    end
    set_cnt(4'd1);
    send(1'b1, 6'd5);
    tick(); tick();
    send(1'b0, 6'd9);
    tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({req_ready, cnt_en, cnt_dir, cnt_load, done, err} !== 6'b100000 || cnt_data !== 6'd0 || steps !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid: got rdy/en/dir/ld/done/err=%b data=%0d steps=%0d want 100000 0 0",
               {req_ready, cnt_en, cnt_dir, cnt_load, done, err}, cnt_data, steps);
    end
  endtask

  task automatic test_step_up();
    set_cnt(4'd3);
    send(1'b0, 6'd7);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if ({cnt_en, cnt_dir, cnt_load, done, err} !== 5'b11000 || steps !== 5'(k)) begin
        errors++;
        $display("FAIL step_up_c%0d: got en/dir/ld/done/err=%b steps=%0d want 11000 steps=%0d",
                 k, {cnt_en, cnt_dir, cnt_load, done, err}, steps, k);
      end
      tick();
    end
    checks++;
    if ({cnt_en, cnt_dir, cnt_load, done, err} !== 5'b01010 || steps !== 5'd4 || cnt_out !== 4'd7) begin
      errors++;
      $display("FAIL step_up_done: got en/dir/ld/done/err=%b steps=%0d cnt=%0d want 01010 4 7",
               {cnt_en, cnt_dir, cnt_load, done, err}, steps, cnt_out);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0 || steps !== 5'd4) begin
      errors++;
      $display("FAIL step_up_idle: got rdy=%b done=%b steps=%0d want 1 0 4", req_ready, done, steps);
    end
  endtask

  task automatic test_step_down();
    set_cnt(4'd9);
    send(1'b0, 6'd2);
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if ({cnt_en, cnt_dir, cnt_load, done, err} !== 5'b10000 || steps !== 5'(k) || cnt_out < 4'd2) begin
        errors++;
        $display("FAIL step_down_c%0d: got en/dir/ld/done/err=%b steps=%0d cnt=%0d want 10000 steps=%0d cnt>=2",
                 k, {cnt_en, cnt_dir, cnt_load, done, err}, steps, cnt_out, k);
      end
      tick();
    end
    checks++;
    if ({cnt_en, cnt_dir, cnt_load, done, err} !== 5'b00010 || steps !== 5'd7 || cnt_out !== 4'd2) begin
      errors++;
      $display("FAIL step_down_done: got en/dir/ld/done/err=%b steps=%0d cnt=%0d want 00010 7 2",
               {cnt_en, cnt_dir, cnt_load, done, err}, steps, cnt_out);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || cnt_out !== 4'd2 || done !== 1'b0) begin
      errors++;
      $display("FAIL step_down_idle: got rdy=%b cnt=%0d done=%b want 1 2 0", req_ready, cnt_out, done);
    end
  endtask

  task automatic test_load();
    set_cnt(4'd4);
    send(1'b1, 6'd10);
    checks++;
    if ({cnt_en, cnt_load, done, err, req_ready} !== 5'b11000 || cnt_data !== 6'd10) begin
      errors++;
      $display("FAIL load_c1: got en/ld/done/err/rdy=%b data=%0d want 11000 10",
               {cnt_en, cnt_load, done, err, req_ready}, cnt_data);
    end
    tick();
    checks++;
    if ({cnt_en, cnt_load, done, err, req_ready} !== 5'b00100 || steps !== 5'd0 || cnt_out !== 4'd10) begin
      errors++;
      $display("FAIL load_c2: got en/ld/done/err/rdy=%b steps=%0d cnt=%0d want 00100 0 10",
               {cnt_en, cnt_load, done, err, req_ready}, steps, cnt_out);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_c3: got rdy=%b done=%b want 1 0", req_ready, done);
    end
  endtask

  task automatic test_reject();
    set_cnt(4'd5);
    send(1'b0, 6'd13);
    checks++;
    if ({cnt_en, cnt_load, done, err} !== 4'b0001 || cnt_out !== 4'd5) begin
      errors++;
      $display("FAIL reject_range: got en/ld/done/err=%b cnt=%0d want 0001 5", {cnt_en, cnt_load, done, err}, cnt_out);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL reject_idle: got rdy=%b err=%b want 1 0", req_ready, err);
    end
    set_cnt(4'd15);
    send(1'b0, 6'd5);
    checks++;
    if ({cnt_en, cnt_load, done, err} !== 4'b0001) begin
      errors++;
      $display("FAIL reject_locked: got en/ld/done/err=%b want 0001", {cnt_en, cnt_load, done, err});
    end
    tick();
    set_cnt(4'd6);
    send(1'b0, 6'd6);
    checks++;
    if ({cnt_en, cnt_load, done, err} !== 4'b0010 || steps !== 5'd0) begin
      errors++;
      $display("FAIL zero_dist: got en/ld/done/err=%b steps=%0d want 0010 0", {cnt_en, cnt_load, done, err}, steps);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_dist_idle: got rdy=%b done=%b want 1 0", req_ready, done);
    end
  endtask

  task automatic test_timeout();
    int bad;
    freeze = 1'b1;
    set_cnt(4'd0);
    send(1'b0, 6'd12);
    bad = 0;
    for (int k = 1; k <= 31; k++) begin
      if (cnt_en !== 1'b1 || err !== 1'b0 || done !== 1'b0 || steps !== 5'(k)) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL timeout_en: got %0d bad stepping cycles want 0", bad);
    end
    checks++;
    if ({cnt_en, done, err} !== 3'b001 || steps !== 5'd31) begin
      errors++;
      $display("FAIL timeout_err: got en/done/err=%b steps=%0d want 001 31", {cnt_en, done, err}, steps);
    end
    tick();
    freeze = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || err !== 1'b0 || steps !== 5'd31) begin
      errors++;
      $display("FAIL timeout_idle: got rdy=%b err=%b steps=%0d want 1 0 31", req_ready, err, steps);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    set_cnt(4'd2);
    send(1'b0, 6'd8);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({cnt_en, done, err} !== 3'b000) begin
      errors++;
      $display("FAIL abort_c3: got en/done/err=%b want 000", {cnt_en, done, err});
    end
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done !== 1'b0 || err !== 1'b0 || cnt_en !== 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 0 || req_ready !== 1'b1 || steps !== 5'd0) begin
      errors++;
      $display("FAIL abort_after: got pulses=%0d rdy=%b steps=%0d want 0 1 0", pulses, req_ready, steps);
    end
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_step_up();
    test_step_down();
    test_load();
    test_reject();
    test_timeout();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
